serial_shift_unit: RTL and testbench
====================================

// Module: serial_shift_unit
// PURPOSE
//  Multi-cycle shift execution stage: accepts operand a, shift amount b and op code,
//  then shifts one bit per cycle. Covers SLL, SRL and SRA (sign fill, same as $signed(a)>>>b).
//  Sits upstream of the result/compare stage and hands it a registered result over valid/ready.
// PARAMETERS
//  WIDTH    4  operand/result width in bits
//  SHAMT_W  4  shift-amount width; amounts >= WIDTH are legal
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  in_valid   in   1        request valid
//  in_ready   out  1        unit can accept (state IDLE)
//  a          in   WIDTH    operand
//  b          in   SHAMT_W  shift amount, unsigned
//  op         in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//  out_valid  out  1        result valid (state DONE)
//  out_ready  in   1        downstream accepts result
//  result     out  WIDTH    shifted value, registered
//  busy       out  1        high in SHIFT or DONE
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, result=0, out_valid=0, busy=0, cnt=0.
//    in_ready=1 while in reset and after release. In-flight op is discarded, no output.
//  - FSM states: IDLE, SHIFT, DONE.
//  - Accept = in_valid & in_ready on a rising edge k.
//    On accept: latch a into result, op into op_q, and set cnt = c.
//    c = min(b, WIDTH) for SLL/SRL/SRA.
//  - On accept, next state: DONE if c==0, else SHIFT.
//  - SHIFT, each edge:
//    - SLL: result = {result[WIDTH-2:0], 1'b0}.
//    - SRL: result = {1'b0, result[WIDTH-1:1]}.
//    - SRA: result = {result[WIDTH-1], result[WIDTH-1:1]}.
//    - cnt decrements by 1; when cnt==1, go to DONE.
//  - Latency: out_valid is first high after edge k+c, where 0 <= c <= WIDTH.
//    No state is a wasted cycle.
//  - DONE: out_valid=1; result held stable while out_ready==0.
//    Edge with out_ready==1 -> IDLE, out_valid=0, result keeps last value.
//  - in_ready = (state==IDLE), combinational from state. No accept while SHIFT or DONE.
//    Back-to-back throughput is 1 op per c+2 cycles.
//  - Saturation:
//    - b >= WIDTH with SLL/SRL gives 0.
//    - b >= WIDTH with SRA gives all copies of a[WIDTH-1].
//  - a, b and op are only sampled at accept; later changes are ignored.
//  - Simultaneous in_valid and out_ready in DONE: the result is retired; the new request
//    is not accepted until the next cycle (IDLE).
// CONFIGURATION
//  SERIAL_SHIFT_ROR_EN
//  - Defined: op 11 = rotate right.
//    - c = b mod WIDTH.
//    - Each SHIFT edge: result = {result[0], result[WIDTH-1:1]}.
//  - Not defined: op 11 behaves exactly as SRL (01). No rotate logic is synthesised.
// TESTING (WIDTH=4, SHAMT_W=4)
//  1. SRA a=4'b1000, b=2 -> out_valid after edge k+2, result=4'b1110.
//     Same request with op SRL -> result=4'b0010.
//  2. SLL a=4'b0111, b=7 -> c clamps to 4; out_valid after edge k+4, result=4'b0000.
//     SRA a=4'b1010, b=9 -> result=4'b1111.
//  3. SRL a=4'b1011, b=0 -> out_valid after edge k+0 (next cycle), result=4'b1011.
//     in_ready low from edge k until retirement.
//  4. Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stay stable, in_ready=0.
//     Raise out_ready -> IDLE next edge.
//  5. Assert reset low mid-SHIFT (SLL, b=3, after 1 shift) -> result=0, out_valid=0, in_ready=1
//     immediately. After release, a new SRL a=4'b1000, b=1 gives 4'b0100.
//  6. op=11, a=4'b0001, b=5:
//     - with SERIAL_SHIFT_ROR_EN: result=4'b1000 after 1 cycle.
//     - without it: result=4'b0000 after 4 cycles.

Source files
------------

// File: rtl/serial_shift_unit.sv
// Multi-cycle serial shifter (SLL/SRL/SRA, one bit per cycle) with valid/ready handshakes.
// Optional rotate-right on op 11 when SERIAL_SHIFT_ROR_EN is defined; otherwise op 11 acts as SRL.
module serial_shift_unit #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   c_amt;
  logic [WIDTH-1:0]   shifted;
  logic [31:0]        b_ext;

  assign b_ext = 32'(b);

  // Shifting more than WIDTH bits changes nothing further, so the count saturates at WIDTH.
  always_comb begin
    if (b_ext >= 32'(WIDTH)) c_amt = CNT_W'(WIDTH);
    else                     c_amt = CNT_W'(b_ext);
`ifdef SERIAL_SHIFT_ROR_EN
    if (op == 2'b11) c_amt = CNT_W'(b_ext % 32'(WIDTH));
`endif
  end

  always_comb begin
    case (op_q)
      2'b00:   shifted = {result_q[WIDTH-2:0], 1'b0};
      2'b10:   shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROR_EN
      2'b11:   shifted = {result_q[0], result_q[WIDTH-1:1]};
`endif
      default: shifted = {1'b0, result_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          result_d = a;
          op_d     = op;
          cnt_d    = c_amt;
          state_d  = (c_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit (WIDTH=4): vector table plus hand sequences for
// DONE back-pressure, retire/request overlap and reset during SHIFT.
module tb_serial_shift_unit;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] a, b;
  logic [1:0] op;
  logic       out_valid, out_ready;
  logic [3:0] result;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_shift_unit #(.WIDTH(4), .SHAMT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one request, measure edges until out_valid, then retire it.
  task automatic run_op(input int idx, input logic [1:0] o, input logic [3:0] av,
                        input logic [3:0] bv, input logic [3:0] er, input int el);
    int lat;
    logic ok;
    @(negedge clk);
    chk($sformatf("v%0d_ready_pre", idx), in_ready, 1);
    in_valid = 1'b1; a = av; b = bv; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; op = ~o;
    lat = 0;
    ok  = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, el);
    chk($sformatf("v%0d_result", idx), result, er);
    chk($sformatf("v%0d_shift_flags", idx), ok, 1);
    chk($sformatf("v%0d_done_flags", idx), {in_ready, busy}, 2'b01);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk($sformatf("v%0d_retire", idx), {out_valid, in_ready, busy}, 3'b010);
    chk($sformatf("v%0d_result_kept", idx), result, er);
  endtask

  initial begin
    vecs[0]  = '{SRA, 4'b1000, 4'd2,  4'b1110, 2};
    vecs[1]  = '{SRL, 4'b1000, 4'd2,  4'b0010, 2};
    vecs[2]  = '{SLL, 4'b0111, 4'd7,  4'b0000, 4};
    vecs[3]  = '{SRA, 4'b1010, 4'd9,  4'b1111, 4};
    vecs[4]  = '{SRL, 4'b1011, 4'd0,  4'b1011, 0};
    vecs[5]  = '{SLL, 4'b0011, 4'd1,  4'b0110, 1};
    vecs[6]  = '{SRA, 4'b0110, 4'd1,  4'b0011, 1};
    vecs[7]  = '{SLL, 4'b1001, 4'd4,  4'b0000, 4};
    vecs[8]  = '{SRA, 4'b0111, 4'd15, 4'b0000, 4};
    vecs[9]  = '{SRL, 4'b1111, 4'd3,  4'b0001, 3};
    vecs[12] = '{SLL, 4'b0101, 4'd3,  4'b1000, 3};
`ifdef SERIAL_SHIFT_ROR_EN
    vecs[10] = '{ROR, 4'b0001, 4'd5,  4'b1000, 1};
    vecs[11] = '{ROR, 4'b0110, 4'd2,  4'b1001, 2};
`else
    vecs[10] = '{ROR, 4'b0001, 4'd5,  4'b0000, 4};
    vecs[11] = '{ROR, 4'b0110, 4'd2,  4'b0001, 2};
`endif

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    #12;
    chk("reset_state", {result, out_valid, busy, in_ready}, 7'b0000_001);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // DONE back-pressure: SRA 1000 by 1 -> 1100, held for 5 cycles.
    @(negedge clk); in_valid = 1'b1; a = 4'b1000; b = 4'd1; op = SRA;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), {out_valid, in_ready, result}, 6'b10_1100);
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("hold_release", {out_valid, in_ready}, 2'b01);

    // Retire and new request on the same edge: request waits for IDLE.
    @(negedge clk); in_valid = 1'b1; a = 4'b0001; b = 4'd1; op = SLL;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ovl_first_done", {out_valid, result}, 5'b1_0010);
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; a = 4'b0010; b = 4'd1; op = SRL;
    @(posedge clk); #1;
    chk("ovl_not_accepted", {out_valid, in_ready, busy}, 3'b010);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("ovl_accepted", {in_ready, busy}, 2'b01);
    @(posedge clk); #1;
    chk("ovl_second_done", {out_valid, result}, 5'b1_0001);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset asserted mid-SHIFT after one shift of SLL by 3.
    @(negedge clk); in_valid = 1'b1; a = 4'b0011; b = 4'd3; op = SLL;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_shift_busy", {busy, result}, 5'b1_0110);
    #2 reset = 1'b0;
    #1;
    chk("rst_async", {result, out_valid, in_ready, busy}, 7'b0000_010);
    @(negedge clk); reset = 1'b1;
    run_op(20, SRL, 4'b1000, 4'd1, 4'b0100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
